dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd200: bus cycles without bus_ack_i before a transaction is aborted.
REQ-002 SHALL have parameter RDATA_RESET, default 32'h0000_0000: reset value of rd_data_o.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_req_i  input  1  store request from write-back stage, sampled only when busy_o=0.
REQ-006 wr_addr_i  input  32  store byte address.
REQ-007 wr_data_i  input  32  store data, already byte-replicated.
REQ-008 wr_byte_i  input  4  store byte enables.
REQ-009 rd_req_i  input  1  load request, sampled only when busy_o=0.
REQ-010 rd_addr_i  input  32  load byte address.
REQ-011 rd_size_i  input  2  load size: 00 byte, 01 half, 10 word.
REQ-012 rd_data_o  output  32  raw load word, held until next load completes.
REQ-013 rd_valid_o  output  1  one-cycle pulse: rd_data_o updated.
REQ-014 busy_o  output  1  controller cannot accept requests.
REQ-015 err_o  output  1  one-cycle pulse: timeout or (with macro) alignment error.
REQ-016 bus_req_o  output  1  bus request, held until ack.
REQ-017 bus_we_o  output  1  1 write, 0 read.
REQ-018 bus_addr_o  output  32  {addr[31:2],2'b00}.
REQ-019 bus_wdata_o / bus_be_o  output  32 / 4  write data / byte enables; bus_be_o=4'b1111 on reads.
REQ-020 bus_ack_i / bus_rdata_i  input  1 / 32  completion strobe / read data valid with ack.

Function
REQ-021 FSM states SHALL be IDLE, WRITE, READ; all outputs registered.
REQ-022 IDLE with wr_req_i=1 at edge N SHALL enter WRITE and assert bus_req_o, bus_we_o=1 with captured address/data/enables at N+1.
REQ-023 IDLE with only rd_req_i=1 at edge N SHALL enter READ, bus_req_o=1, bus_we_o=0 at N+1.
REQ-024 Simultaneous wr_req_i and rd_req_i SHALL issue the write first, capture the read (address, size) into a one-entry pending register, and issue the read the cycle after the write ack.
REQ-025 bus_* outputs SHALL stay stable while bus_req_o=1.
REQ-026 bus_ack_i at edge M in WRITE/READ SHALL drop bus_req_o at M+1 and return to IDLE (or READ if a read is pending).
REQ-027 Read ack at edge M SHALL load rd_data_o=bus_rdata_i and pulse rd_valid_o at M+1.
REQ-028 bus_ack_i in IDLE SHALL be ignored.
REQ-029 busy_o SHALL be 1 when state!=IDLE or pending valid; requests while busy_o=1 SHALL be ignored.
REQ-030 An 8-bit wait counter SHALL clear on entering WRITE/READ and increment each non-ack cycle; reaching TIMEOUT SHALL drop bus_req_o, pulse err_o, and for reads pulse rd_valid_o with rd_data_o=32'h0; pending read SHALL then be issued normally.
REQ-031 Ack arriving on the same edge as timeout SHALL be treated as success (no err_o).

Reset
REQ-032 reset low SHALL immediately force IDLE, clear pending and counter, bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_wdata_o=0, bus_be_o=0, rd_valid_o=0, err_o=0, busy_o=0, rd_data_o=RDATA_RESET, aborting any transaction in flight.

Configuration
REQ-033 With DMEM_ALIGN_CHECK_EN defined: loads with size half and addr[0]=1 or size word and addr[1:0]!=0, and stores whose wr_byte_i is not one of 0001/0010/0100/1000/0011/1100/1111, SHALL not reach the bus; err_o SHALL pulse the next cycle (loads also pulse rd_valid_o with rd_data_o=0); state stays IDLE.
REQ-034 Without DMEM_ALIGN_CHECK_EN: no checking; all requests issued; rd_size_i unused.

Verification
REQ-035 Write addr 32'h0000_1006, data 32'hABCD_ABCD, be 4'b1100, ack after 3 cycles -> bus_addr_o=32'h0000_1004, bus_be_o=1100, bus_req_o high 3 cycles then low, busy_o low after.
REQ-036 Read addr 32'h20, ack same cycle with rdata 32'hDEAD_BEEF -> rd_valid_o one pulse, rd_data_o=32'hDEAD_BEEF held afterwards.
REQ-037 Simultaneous write 32'h40 and read 32'h80 -> write transaction first, read issued cycle after write ack, busy_o continuous until read completes.
REQ-038 Read with no ack, TIMEOUT=4 -> bus_req_o drops after 4 wait cycles, err_o and rd_valid_o pulse, rd_data_o=0.
REQ-039 reset low mid-WRITE -> bus_req_o=0 and busy_o=0 immediately; later ack ignored.
REQ-040 DMEM_ALIGN_CHECK_EN, word read at 32'h0000_0102 -> no bus_req_o, err_o and rd_valid_o pulse next cycle, rd_data_o=0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory bus controller; one write or read in flight plus a one-entry pending read.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned loads and illegal store byte enables before the bus.
module dmem_ctrl #(
  parameter logic [7:0]  TIMEOUT     = 8'd200,
  parameter logic [31:0] RDATA_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_req_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_byte_i,
  input  logic        rd_req_i,
  input  logic [31:0] rd_addr_i,
  input  logic [1:0]  rd_size_i,
  output logic [31:0] rd_data_o,
  output logic        rd_valid_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        pend_v, pend_v_n;
  logic [29:0] pend_addr, pend_addr_n;
  logic        bus_req_n, bus_we_n, rd_valid_n, err_n, busy_n;
  logic [31:0] bus_addr_n, bus_wdata_n, rd_data_n;
  logic [3:0]  bus_be_n;
  logic        wr_be_legal, rd_aligned, unused_bits;
  logic        wr_ok, wr_bad, rd_ok, rd_bad, timeout;

`ifdef DMEM_ALIGN_CHECK_EN
  always_comb begin
    case (wr_byte_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: wr_be_legal = 1'b1;
      default:                   wr_be_legal = 1'b0;
    endcase
    case (rd_size_i)
      2'b01:   rd_aligned = ~rd_addr_i[0];
      2'b10:   rd_aligned = (rd_addr_i[1:0] == 2'b00);
      default: rd_aligned = 1'b1;
    endcase
  end
  assign unused_bits = ^wr_addr_i[1:0];
`else
  assign wr_be_legal = 1'b1;
  assign rd_aligned  = 1'b1;
  assign unused_bits = ^{rd_size_i, rd_addr_i[1:0], wr_addr_i[1:0]};
`endif

  assign wr_ok   = wr_req_i & wr_be_legal;
  assign wr_bad  = wr_req_i & ~wr_be_legal;
  assign rd_ok   = rd_req_i & rd_aligned;
  assign rd_bad  = rd_req_i & ~rd_aligned;
  assign timeout = (cnt == TIMEOUT - 8'd1);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pend_v_n    = pend_v;
    pend_addr_n = pend_addr;
    bus_req_n   = bus_req_o;
    bus_we_n    = bus_we_o;
    bus_addr_n  = bus_addr_o;
    bus_wdata_n = bus_wdata_o;
    bus_be_n    = bus_be_o;
    rd_data_n   = rd_data_o;
    rd_valid_n  = 1'b0;
    err_n       = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ok) begin
          state_n     = WRITE;
          cnt_n       = 8'd0;
          bus_req_n   = 1'b1;
          bus_we_n    = 1'b1;
          bus_addr_n  = {wr_addr_i[31:2], 2'b00};
          bus_wdata_n = wr_data_i;
          bus_be_n    = wr_byte_i;
          if (rd_ok) begin
            pend_v_n    = 1'b1;
            pend_addr_n = rd_addr_i[31:2];
          end
        end else if (rd_ok) begin
          state_n    = READ;
          cnt_n      = 8'd0;
          bus_req_n  = 1'b1;
          bus_we_n   = 1'b0;
          bus_addr_n = {rd_addr_i[31:2], 2'b00};
          bus_be_n   = 4'b1111;
        end
        if (wr_bad || rd_bad) err_n = 1'b1;
        if (rd_bad) begin
          rd_valid_n = 1'b1;
          rd_data_n  = 32'h0;
        end
      end
      WRITE: begin
        if (bus_ack_i || timeout) begin
          err_n     = ~bus_ack_i;
          bus_req_n = 1'b0;
          if (pend_v) begin
            // Pending read: put its address on the bus now, raise the request next cycle.
            state_n    = READ;
            pend_v_n   = 1'b0;
            cnt_n      = 8'd0;
            bus_we_n   = 1'b0;
            bus_addr_n = {pend_addr, 2'b00};
            bus_be_n   = 4'b1111;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      READ: begin
        if (!bus_req_o) begin
          bus_req_n = 1'b1;
        end else if (bus_ack_i || timeout) begin
          state_n    = IDLE;
          bus_req_n  = 1'b0;
          rd_valid_n = 1'b1;
          err_n      = ~bus_ack_i;
          rd_data_n  = bus_ack_i ? bus_rdata_i : 32'h0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE) | pend_v_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      pend_v      <= 1'b0;
      pend_addr   <= 30'd0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'h0;
      bus_wdata_o <= 32'h0;
      bus_be_o    <= 4'b0000;
      rd_data_o   <= RDATA_RESET;
      rd_valid_o  <= 1'b0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pend_v      <= pend_v_n;
      pend_addr   <= pend_addr_n;
      bus_req_o   <= bus_req_n;
      bus_we_o    <= bus_we_n;
      bus_addr_o  <= bus_addr_n;
      bus_wdata_o <= bus_wdata_n;
      bus_be_o    <= bus_be_n;
      rd_data_o   <= rd_data_n;
      rd_valid_o  <= rd_valid_n;
      err_o       <= err_n;
      busy_o      <= busy_n;
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed stimulus with expected bus transactions and load/error responses
// queued up front; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dmem_ctrl;
  localparam logic [31:0] RST_VAL = 32'h5A5A_0000;

  logic        clk = 1'b0, reset = 1'b1;
  logic        wr_req_i = 1'b0, rd_req_i = 1'b0, bus_ack_i = 1'b0;
  logic [31:0] wr_addr_i = '0, wr_data_i = '0, rd_addr_i = '0, bus_rdata_i = '0;
  logic [3:0]  wr_byte_i = '0;
  logic [1:0]  rd_size_i = '0;
  logic [31:0] rd_data_o, bus_addr_o, bus_wdata_o;
  logic        rd_valid_o, busy_o, err_o, bus_req_o, bus_we_o;
  logic [3:0]  bus_be_o;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT(8'd4), .RDATA_RESET(RST_VAL)) dut (
    .clk(clk), .reset(reset),
    .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_byte_i(wr_byte_i),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_size_i(rd_size_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .busy_o(busy_o), .err_o(err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} bus_t;
  typedef struct packed {logic valid; logic err; logic [31:0] data;} resp_t;

  bus_t  exp_bus[$];
  resp_t exp_resp[$];
  int    checks = 0, errors = 0;
  logic  req_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    bus_t  eb;
    resp_t er;
    if (bus_req_o && !req_prev) begin
      if (exp_bus.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected got addr=%h exp none", bus_addr_o);
      end else begin
        eb = exp_bus.pop_front();
        chk("bus_we", bus_we_o, eb.we);
        chk("bus_addr", bus_addr_o, eb.addr);
        chk("bus_be", bus_be_o, eb.be);
        if (eb.we) chk("bus_wdata", bus_wdata_o, eb.wdata);
      end
    end
    req_prev = bus_req_o;
    if (rd_valid_o || err_o) begin
      if (exp_resp.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected got valid=%b err=%b data=%h exp none", rd_valid_o, err_o, rd_data_o);
      end else begin
        er = exp_resp.pop_front();
        chk("resp_valid_err", {rd_valid_o, err_o}, {er.valid, er.err});
        if (er.valid) chk("resp_data", rd_data_o, er.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [3:0] wb, input logic rd, input logic [31:0] ra,
                       input logic [1:0] rs);
    wr_req_i = wr; wr_addr_i = wa; wr_data_i = wd; wr_byte_i = wb;
    rd_req_i = rd; rd_addr_i = ra; rd_size_i = rs;
    tick();
    wr_req_i = 1'b0; rd_req_i = 1'b0;
  endtask

  // Answers one bus transaction: ack in the n-th cycle of bus_req_o (n=0 never acks).
  task automatic serve(input int n, input logic [31:0] rdata, output int hi,
                       output logic stable, output int idle_seen);
    int   guard = 0;
    bus_t first;
    hi = 0; stable = 1'b1; idle_seen = 0; first = '0;
    while (!bus_req_o && guard < 20) begin
      if (!busy_o) idle_seen++;
      tick(); guard++;
    end
    if (!bus_req_o) begin
      checks++; errors++;
      $display("FAIL serve_start got bus_req=0 exp 1 within 20 cycles");
    end
    while (bus_req_o && hi < 20) begin
      hi++;
      if (!busy_o) idle_seen++;
      if (hi == 1) first = {bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o};
      else if ({bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o} !== first) stable = 1'b0;
      if (hi == n) begin bus_ack_i = 1'b1; bus_rdata_i = rdata; end
      tick();
      bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin : stim
    int   hi, idle;
    logic st;
    #2 reset = 1'b0;
    #1;
    chk("rst_bus_req", bus_req_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_rd_data", rd_data_o, RST_VAL);
    chk("rst_bus_be", bus_be_o, 4'b0000);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // store with sub-word address, ack in third cycle
    exp_bus.push_back({1'b1, 32'h0000_1004, 32'hABCD_ABCD, 4'b1100});
    issue(1, 32'h0000_1006, 32'hABCD_ABCD, 4'b1100, 0, 0, 0);
    serve(3, 0, hi, st, idle);
    chk("wr_req_cycles", hi, 3);
    chk("wr_stable", st, 1'b1);
    chk("wr_busy_after", busy_o, 1'b0);

    // load acked in first cycle
    exp_bus.push_back({1'b0, 32'h0000_0020, 32'h0, 4'b1111});
    exp_resp.push_back({1'b1, 1'b0, 32'hDEAD_BEEF});
    issue(0, 0, 0, 0, 1, 32'h0000_0020, 2'b10);
    serve(1, 32'hDEAD_BEEF, hi, st, idle);
    chk("rd_req_cycles", hi, 1);
    tick(); tick();
    chk("rd_data_held", rd_data_o, 32'hDEAD_BEEF);
    chk("rd_valid_single", rd_valid_o, 1'b0);

    // simultaneous store and load: store first, load from the pending register
    exp_bus.push_back({1'b1, 32'h0000_0040, 32'h1111_2222, 4'b1111});
    exp_bus.push_back({1'b0, 32'h0000_0080, 32'h0, 4'b1111});
    exp_resp.push_back({1'b1, 1'b0, 32'hCAFE_F00D});
    issue(1, 32'h0000_0040, 32'h1111_2222, 4'b1111, 1, 32'h0000_0080, 2'b10);
    serve(2, 0, hi, st, idle);
    chk("sim_wr_cycles", hi, 2);
    chk("sim_wr_busy_gaps", idle, 0);
    chk("sim_busy_between", busy_o, 1'b1);
    serve(2, 32'hCAFE_F00D, hi, st, idle);
    chk("sim_rd_cycles", hi, 2);
    chk("sim_rd_busy_gaps", idle, 0);
    chk("sim_busy_after", busy_o, 1'b0);

    // ack while idle must be ignored
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
    tick(); tick();
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    chk("idle_ack_req", bus_req_o, 1'b0);
    chk("idle_ack_busy", busy_o, 1'b0);

    // load timeout
    exp_bus.push_back({1'b0, 32'h0000_0030, 32'h0, 4'b1111});
    exp_resp.push_back({1'b1, 1'b1, 32'h0});
    issue(0, 0, 0, 0, 1, 32'h0000_0030, 2'b10);
    serve(0, 0, hi, st, idle);
    chk("rd_to_cycles", hi, 4);
    chk("rd_to_data", rd_data_o, 32'h0);

    // store timeout
    exp_bus.push_back({1'b1, 32'h0000_0050, 32'h0000_0077, 4'b0001});
    exp_resp.push_back({1'b0, 1'b1, 32'h0});
    issue(1, 32'h0000_0050, 32'h0000_0077, 4'b0001, 0, 0, 0);
    serve(0, 0, hi, st, idle);
    chk("wr_to_cycles", hi, 4);

    // ack on the timeout edge counts as success
    exp_bus.push_back({1'b0, 32'h0000_0060, 32'h0, 4'b1111});
    exp_resp.push_back({1'b1, 1'b0, 32'h1234_5678});
    issue(0, 0, 0, 0, 1, 32'h0000_0060, 2'b10);
    serve(4, 32'h1234_5678, hi, st, idle);
    chk("to_ack_cycles", hi, 4);

    // load request while busy is dropped
    exp_bus.push_back({1'b1, 32'h0000_0070, 32'h55AA_55AA, 4'b0011});
    issue(1, 32'h0000_0070, 32'h55AA_55AA, 4'b0011, 0, 0, 0);
    rd_req_i = 1'b1; rd_addr_i = 32'h0000_0090;
    tick();
    rd_req_i = 1'b0;
    serve(2, 0, hi, st, idle);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_ignored_req", bus_req_o, 1'b0);
    end
    chk("busy_ignored_busy", busy_o, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    exp_resp.push_back({1'b1, 1'b1, 32'h0});
    issue(0, 0, 0, 0, 1, 32'h0000_0102, 2'b10);
    chk("align_rd_req", bus_req_o, 1'b0);
    chk("align_rd_busy", busy_o, 1'b0);
    exp_resp.push_back({1'b0, 1'b1, 32'h0});
    issue(1, 32'h0000_0300, 32'h0, 4'b0101, 0, 0, 0);
    chk("align_wr_req", bus_req_o, 1'b0);
    tick();
    chk("align_wr_idle", bus_req_o, 1'b0);
`else
    exp_bus.push_back({1'b0, 32'h0000_0100, 32'h0, 4'b1111});
    exp_resp.push_back({1'b1, 1'b0, 32'h0BAD_F00D});
    issue(0, 0, 0, 0, 1, 32'h0000_0102, 2'b10);
    serve(1, 32'h0BAD_F00D, hi, st, idle);
    chk("noalign_rd_cycles", hi, 1);
`endif

    // reset in the middle of a store
    exp_bus.push_back({1'b1, 32'h0000_0200, 32'h9999_0000, 4'b1111});
    issue(1, 32'h0000_0200, 32'h9999_0000, 4'b1111, 0, 0, 0);
    tick();
    chk("pre_rst_req", bus_req_o, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", bus_req_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    tick();
    reset = 1'b1;
    bus_ack_i = 1'b1;
    tick();
    bus_ack_i = 1'b0;
    tick();
    chk("post_rst_req", bus_req_o, 1'b0);
    chk("post_rst_busy", busy_o, 1'b0);
    chk("post_rst_data", rd_data_o, RST_VAL);

    tick(); tick();
    chk("bus_queue_empty", exp_bus.size(), 0);
    chk("resp_queue_empty", exp_resp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
